// File: rtl/ro_ctrl_pkg.sv
// Shared definitions for the ring-oscillator frequency meter.
//   state_e         : sequencer states
//   SETTLE_CYC_DEF  : default number of settle cycles before counting
//   max_i           : integer max, used for sizing the shared down-counter
package ro_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_MEASURE = 2'd2
  } state_e;

  localparam int SETTLE_CYC_DEF = 16;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// Brings the free-running ring output into the clk domain and produces a
// one-cycle pulse per rising edge.
//   clk        in  system clock
//   rst_n      in  async reset, active low (clears all sync flops)
//   async_in   in  ring oscillator output, asynchronous to clk
//   rise_pulse out high for one clk when a synchronized rising edge is seen
module ro_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_pulse
);

  // s1/s2 form the metastability synchronizer; s3 is the history flop.
  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise_pulse = s2 & ~s3;

endmodule

// File: rtl/ro_freq_meter_ctrl.sv
// Ring-oscillator frequency meter sequencer: enables the ring, lets it
// settle for SETTLE_CYC clks, counts ring rising edges for win_len clks,
// then disables the ring and reports the count with a done pulse.
//   clk, rst_n  clock, async active-low reset
//   start       level-sampled; accepted only in IDLE
//   abort       cancels SETTLE/MEASURE, clears result, no done pulse
//   win_len     window length in clks, latched when start is accepted
//   ro_in       ring output (async)
//   ro_en       ring enable, 1 = oscillate
//   busy        high in SETTLE and MEASURE
//   done        one-cycle completion pulse
//   count       edges counted in the last window (saturating)
//   ovf         an edge arrived while count was already all-ones
module ro_freq_meter_ctrl
  import ro_ctrl_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] win_len,
  input  logic             ro_in,
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  // One down-counter times both the settle phase and the window.
  localparam int TMR_W = max_i(WIN_W, $clog2(SETTLE_CYC + 1));
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state;
  logic [TMR_W-1:0] tmr;
  logic [WIN_W-1:0] win_q;
  logic             rise;

  ro_edge_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (ro_in),
    .rise_pulse (rise)
  );

  // Timer holds "cycles remaining minus one" in the current phase, so the
  // phase ends on the cycle where it reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      tmr   <= '0;
      win_q <= '0;
      ro_en <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // abort in the same cycle suppresses the start
          if (start && !abort) begin
            win_q <= win_len;
            count <= '0;
            ovf   <= 1'b0;
            if (win_len == '0) begin
              done <= 1'b1;
            end else begin
              state <= S_SETTLE;
              ro_en <= 1'b1;
              busy  <= 1'b1;
              tmr   <= SETTLE_LD;
            end
          end
        end

        S_SETTLE: begin
          if (abort) begin
            state <= S_IDLE;
            ro_en <= 1'b0;
            busy  <= 1'b0;
            count <= '0;
            ovf   <= 1'b0;
          end else if (tmr == '0) begin
            state <= S_MEASURE;
            tmr   <= TMR_W'(win_q) - TMR_ONE;
          end else begin
            tmr <= tmr - TMR_ONE;
          end
        end

        S_MEASURE: begin
          if (abort) begin
            state <= S_IDLE;
            ro_en <= 1'b0;
            busy  <= 1'b0;
            count <= '0;
            ovf   <= 1'b0;
          end else begin
            if (rise) begin
              if (count == '1) ovf   <= 1'b1;
              else             count <= count + CNT_ONE;
            end
            if (tmr == '0) begin
              state <= S_IDLE;
              ro_en <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              tmr <= tmr - TMR_ONE;
            end
          end
        end

        default: begin
          state <= S_IDLE;
          ro_en <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
